rr_mux_4_1_arbiter: RTL



---
 rtl/rr_mux_4_1_arbiter_pkg.sv | 20 ++
 rtl/rr_mux_4_1_arbiter_pick.sv | 26 ++
 rtl/rr_mux_4_1_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rr_mux_4_1_arbiter_pkg.sv
// Shared constants for the round-robin 4:1 mux arbiter: FSM encoding, default
// parameters and hold-counter sizing helpers.
package rr_mux_4_1_arbiter_pkg;

    localparam logic IDLE  = 1'b0;
    localparam logic GRANT = 1'b1;

    localparam int unsigned DEFAULT_W        = 2;
    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    // Counter only has to reach MAX_HOLD-1; keep at least one bit for MAX_HOLD=1.
    function automatic int unsigned hold_cnt_width(input int unsigned max_hold);
        return (max_hold > 1) ? $clog2(max_hold) : 1;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/rr_mux_4_1_arbiter_pick.sv
// Round-robin picker: first asserted request scanning last+1 .. last+4 (mod 4).
module rr_pick_4
    import rr_mux_4_1_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        // Descending scan so the nearest position after last wins; k=4 wraps to last.
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_4_1_arbiter.sv
// Round-robin arbiter owning a shared 4:1 data mux; one-hot grants, hold-limited
// tenures and a registered output beat with a valid flag.
module rr_mux_4_1_arbiter
    import rr_mux_4_1_arbiter_pkg::*;
#(
    parameter int unsigned W        = DEFAULT_W,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [W-1:0] y,
    output logic         y_valid,
    output logic         busy
);

    localparam int unsigned HW = hold_cnt_width(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    logic          state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    last_q, last_d;
    logic [W-1:0]  y_q, y_d;
    logic          y_valid_q, y_valid_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]   pick;
    logic         any;
    logic [W-1:0] d_sel;
    logic         other_req;
    logic         forced;

    rr_pick_4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        d_sel = '0;
        case (sel_q)
            2'd0:    d_sel = d0;
            2'd1:    d_sel = d1;
            2'd2:    d_sel = d2;
            default: d_sel = d3;
        endcase
    end

    assign other_req = |(req & ~onehot4(sel_q));
    assign forced    = (hold_cnt_q == HOLD_MAX) && other_req;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                y_valid_d = 1'b0;
                if (any) begin
                    gnt_d      = onehot4(pick);
                    sel_d      = pick;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (req[sel_q]) begin
                    // The beat is captured even on the cycle a forced release happens.
                    y_d       = d_sel;
                    y_valid_d = 1'b1;
                    if (forced) begin
                        gnt_d   = '0;
                        last_d  = sel_q;
                        state_d = IDLE;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    y_valid_d = 1'b0;
                    gnt_d     = '0;
                    last_d    = sel_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            last_q     <= 2'd3;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = (state_q == GRANT);

endmodule
